// File: rtl/dphy_rx_pkg.sv
// Shared constants for the D-PHY data lane receiver: FSM state codes,
// the HS sync byte and the LP line-state codes.
package dphy_rx_pkg;

    localparam logic [2:0] ST_STOP        = 3'd0;
    localparam logic [2:0] ST_HS_RQST     = 3'd1;
    localparam logic [2:0] ST_SYNC_SEARCH = 3'd2;
    localparam logic [2:0] ST_HS_DATA     = 3'd3;
    localparam logic [2:0] ST_FLUSH       = 3'd4;
    localparam logic [2:0] ST_WAIT_STOP   = 3'd5;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    // LP codes are {LP-Dp, LP-Dn}
    localparam logic [1:0] LP_11 = 2'b11;
    localparam logic [1:0] LP_01 = 2'b01;
    localparam logic [1:0] LP_00 = 2'b00;
    localparam logic [1:0] LP_10 = 2'b10;

endpackage

// File: rtl/dphy_rx_aligner.sv
// Byte aligner: finds the sync byte at any bit offset in a two-byte window
// and, once locked, presents the payload byte at that offset every cycle.
module dphy_rx_aligner
    import dphy_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] hs_byte_in,
    input  logic       search,
    output logic       found,
    output logic [7:0] aligned
);

    logic [7:0]  prev;
    logic [2:0]  k;
    logic [2:0]  hit_k;
    logic [15:0] window;

    // Bit 0 is earliest on the wire, so the previous byte forms the low half.
    assign window  = {hs_byte_in, prev};
    assign aligned = window[k +: 8];

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        found = 1'b0;
        hit_k = '0;
        // Descending scan: the last assignment is the lowest matching offset.
        for (int i = 7; i >= 0; i--) begin
            if (window[i +: 8] == SYNC_BYTE) begin
                found = 1'b1;
                hit_k = 3'(i);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
            k    <= '0;
        end else begin
            prev <= hs_byte_in;
            if (search && found)
                k <= hit_k;
        end
    end

endmodule

// File: rtl/dphy_lane_receiver.sv
// D-PHY data lane receiver: LP start/stop sequencing, sync lock, trail
// dropping delay line and burst framing of the aligned payload bytes.
module dphy_lane_receiver
    import dphy_rx_pkg::*;
#(
    parameter int SYNC_TIMEOUT = 16,
    parameter int TRAIL_DROP   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] lp_in,
    input  logic [7:0] hs_byte_in,
    output logic       hs_enable_out,
    output logic [7:0] rx_data_out,
    output logic       rx_valid_out,
    output logic       rx_sop_out,
    output logic       rx_eop_out,
    output logic       err_sot_out,
    output logic       err_sync_out,
    output logic       err_eot_out
);

    localparam int DEPTH  = TRAIL_DROP + 1;
    localparam int LINE_W = $clog2(DEPTH + 1);
    localparam int CNT_W  = $clog2(SYNC_TIMEOUT + 1);

    logic [1:0]        lp_meta;
    logic [1:0]        lp_s;
    logic [2:0]        state;
    logic [2:0]        state_next;
    logic              found;
    logic [7:0]        aligned;
    logic [CNT_W-1:0]  sync_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic [7:0]        line [DEPTH];
    logic              sop_pending;
    logic              push;
    logic              line_full;
    logic              timeout;

    dphy_rx_aligner u_aligner (
        .clk        (clk),
        .rst        (rst),
        .hs_byte_in (hs_byte_in),
        .search     (state == ST_SYNC_SEARCH),
        .found      (found),
        .aligned    (aligned)
    );

    // Line idles at LP-11, so the synchronizer resets to that code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lp_meta <= LP_11;
            lp_s    <= LP_11;
        end else begin
            lp_meta <= lp_in;
            lp_s    <= lp_meta;
        end
    end

    assign hs_enable_out = (state == ST_SYNC_SEARCH) || (state == ST_HS_DATA);
    assign push          = (state == ST_HS_DATA) && (lp_s != LP_11);
    assign line_full     = (line_cnt == LINE_W'(DEPTH));
    assign timeout       = (sync_cnt == CNT_W'(SYNC_TIMEOUT - 1));

    always_comb begin
        state_next = state;
        case (state)
            ST_STOP:        if (lp_s == LP_01) state_next = ST_HS_RQST;
            ST_HS_RQST: begin
                case (lp_s)
                    LP_00:   state_next = ST_SYNC_SEARCH;
                    LP_11:   state_next = ST_STOP;
                    LP_10:   state_next = ST_WAIT_STOP;
                    default: state_next = ST_HS_RQST;
                endcase
            end
            ST_SYNC_SEARCH: begin
                if (lp_s == LP_11)  state_next = ST_STOP;
                else if (found)     state_next = ST_HS_DATA;
                else if (timeout)   state_next = ST_WAIT_STOP;
            end
            ST_HS_DATA:     if (lp_s == LP_11) state_next = ST_FLUSH;
            ST_FLUSH:       state_next = ST_STOP;
            ST_WAIT_STOP:   if (lp_s == LP_11) state_next = ST_STOP;
            default:        state_next = ST_STOP;
        endcase
    end

    // NOTE: the delay line payload is not reset; line_cnt alone defines emptiness.
    always_ff @(posedge clk) begin
        if (push) begin
            line[0] <= aligned;
            for (int i = 1; i < DEPTH; i++)
                line[i] <= line[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_STOP;
            sync_cnt     <= '0;
            line_cnt     <= '0;
            sop_pending  <= 1'b1;
            rx_data_out  <= '0;
            rx_valid_out <= 1'b0;
            rx_sop_out   <= 1'b0;
            rx_eop_out   <= 1'b0;
            err_sot_out  <= 1'b0;
            err_sync_out <= 1'b0;
            err_eot_out  <= 1'b0;
        end else begin
            state        <= state_next;
            rx_valid_out <= 1'b0;
            rx_sop_out   <= 1'b0;
            rx_eop_out   <= 1'b0;
            err_sot_out  <= 1'b0;
            err_sync_out <= 1'b0;
            err_eot_out  <= 1'b0;
            sync_cnt     <= (state == ST_SYNC_SEARCH) ? sync_cnt + 1'b1 : '0;
            case (state)
                ST_STOP: begin
                    line_cnt    <= '0;
                    sop_pending <= 1'b1;
                end
                ST_HS_RQST:
                    if (lp_s == LP_10) err_sot_out <= 1'b1;
                ST_SYNC_SEARCH:
                    if (lp_s == LP_11 || (!found && timeout)) err_sync_out <= 1'b1;
                ST_HS_DATA: begin
                    // A push into a full line retires the oldest byte.
                    if (push && line_full) begin
                        rx_data_out  <= line[DEPTH-1];
                        rx_valid_out <= 1'b1;
                        rx_sop_out   <= sop_pending;
                        sop_pending  <= 1'b0;
                    end else if (push) begin
                        line_cnt <= line_cnt + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // Only the oldest entry is payload; the newer ones are trail.
                    if (line_full) begin
                        rx_data_out  <= line[DEPTH-1];
                        rx_valid_out <= 1'b1;
                        rx_sop_out   <= sop_pending;
                        rx_eop_out   <= 1'b1;
                    end else begin
                        err_eot_out <= 1'b1;
                    end
                    line_cnt    <= '0;
                    sop_pending <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dphy_lane_receiver.md
DPHY_LANE_RECEIVER -- requirements
Module: dphy_lane_receiver

Interface
REQ-001 SHALL have parameter SYNC_TIMEOUT, default 16: max clk cycles in SYNC_SEARCH before sync error.
REQ-002 SHALL have parameter TRAIL_DROP, default 2: HS bytes discarded at burst end (EoT trail plus LP-detect latency).
REQ-003 SHALL have one clock and an asynchronous, active-high reset: ports clk and rst.
REQ-004 clk  in  1  byte clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 lp_in  in  2  {LP-Dp, LP-Dn} line state, asynchronous to clk.
REQ-007 hs_byte_in  in  8  deserialized HS byte, one per clk, bit 0 earliest on wire.
REQ-008 hs_enable_out  out  1  HS termination/deserializer enable.
REQ-009 rx_data_out  out  8  aligned payload byte.
REQ-010 rx_valid_out  out  1  rx_data_out valid this cycle.
REQ-011 rx_sop_out  out  1  first payload byte of burst (qualified by rx_valid_out).
REQ-012 rx_eop_out  out  1  last kept payload byte of burst (qualified by rx_valid_out).
REQ-013 err_sot_out  out  1  one-cycle pulse: illegal SoT LP sequence.
REQ-014 err_sync_out  out  1  one-cycle pulse: sync not found, or burst aborted before sync.
REQ-015 err_eot_out  out  1  one-cycle pulse: burst ended with fewer than TRAIL_DROP+1 payload bytes.

Function
REQ-016 lp_in SHALL pass a 2-flop synchronizer (lp_s); all LP decisions use lp_s.
REQ-017 States: STOP, HS_RQST, SYNC_SEARCH, HS_DATA, FLUSH, WAIT_STOP.
REQ-018 STOP: lp_s=01 -> HS_RQST; else stay.
REQ-019 HS_RQST: lp_s=00 -> SYNC_SEARCH; 11 -> STOP, no error; 10 -> WAIT_STOP, err_sot_out pulse.
REQ-020 hs_enable_out SHALL be 1 exactly in SYNC_SEARCH and HS_DATA.
REQ-021 Aligner: 16-bit window {hs_byte_in, previous hs_byte_in}; match when window[k+7:k]=8'hB8, k in 0..7; lowest k wins.
REQ-022 SYNC_SEARCH: first match locks k, -> HS_DATA; sync byte never emitted.
REQ-023 SYNC_SEARCH: lp_s=11 or SYNC_TIMEOUT cycles elapsed without match -> err_sync_out pulse; lp_s=11 -> STOP, timeout -> WAIT_STOP.
REQ-024 HS_DATA: each cycle window[k+7:k] pushed into delay line of depth TRAIL_DROP+1; when full, push pops oldest onto rx_data_out with rx_valid_out=1.
REQ-025 rx_sop_out SHALL accompany the first popped byte of each burst only.
REQ-026 HS_DATA: lp_s=11 -> FLUSH, no push that cycle.
REQ-027 FLUSH (one cycle): line full -> oldest entry emitted with rx_valid_out=1, rx_eop_out=1 (and rx_sop_out=1 if first), rest discarded; line not full -> nothing emitted, err_eot_out pulse; -> STOP; line cleared.
REQ-028 WAIT_STOP: lp_s=11 -> STOP; outputs idle.
REQ-029 rx_valid_out, rx_sop_out, rx_eop_out and error pulses SHALL be registered, one cycle wide.
REQ-030 Latency: payload byte appears on rx_data_out TRAIL_DROP+1 cycles after its aligned window.

Reset
REQ-031 rst SHALL asynchronously force STOP, lp_s and synchronizer flops to 2'b11, delay line empty, k=0, timeout counter 0, all outputs 0.
REQ-032 rst asserted mid-burst SHALL discard buffered bytes without emitting eop or errors.

Structure
REQ-033 Shared package dphy_rx_pkg SHALL hold the state enum, SYNC_BYTE=8'hB8 and LP code constants (LP_11, LP_01, LP_00, LP_10).
REQ-034 Window/offset search SHALL be sub-module dphy_rx_aligner; rest in dphy_lane_receiver.

Verification
REQ-035 LP 11->01->00, bytes with B8 at k=0, payload 11,22,33,44, trail FF,FF, LP-11 -> bytes 11,22,33,44; sop on 11, eop on 44 (TRAIL_DROP=2, LP latency aligned).
REQ-036 Same burst with stream shifted 3 bits -> k=3 locked, identical output bytes.
REQ-037 LP 11->01->10 -> err_sot_out one pulse, no hs_enable_out, STOP only after LP-11.
REQ-038 SoT then 20 cycles of 00 bytes -> err_sync_out pulse at cycle 16 of SYNC_SEARCH, hs_enable_out drops.
REQ-039 Sync then 2 payload bytes then LP-11 -> no rx_valid_out, err_eot_out pulse.
REQ-040 rst asserted during HS_DATA with 3 bytes buffered -> outputs 0 immediately, no eop; next clean burst received correctly.
